// File: rtl/brg_wb2ps_pkg.sv
// brg_wb2ps_pkg: shared types for the Wishbone-to-PSRAM write FIFO
// Holds the FIFO entry layout {adr, sel, dat}, its width and the drain FSM states.
package brg_wb2ps_pkg;
  localparam int ADR_W = 21;
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [3:0]       sel;
    logic [31:0]      dat;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} drain_t;
endpackage

// File: rtl/brg_wb2ps_wfifo_ctrl_if.sv
// brg_wb2ps_wfifo_ctrl_if: Wishbone write slave, PSRAM write-command and FIFO status signals
// slave modport: the FIFO controller; master modport: the bus/PSRAM side driving it.
interface brg_wb2ps_wfifo_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WB_AW      = 23
);
  logic                  wb_cyc_i;
  logic                  wb_stb_i;
  logic                  wb_we_i;
  logic [WB_AW-1:0]      wb_adr_i;
  logic [31:0]           wb_dat_i;
  logic [3:0]            wb_sel_i;
  logic                  wb_ack_o;
  logic                  wb_err_o;
  logic                  ps_req_o;
  logic                  ps_ack_i;
  logic [WB_AW-3:0]      ps_adr_o;
  logic [31:0]           ps_dat_o;
  logic [3:0]            ps_sel_o;
  logic [ADDR_WIDTH:0]   fifo_count_o;
  logic                  fifo_empty_o;
  logic                  fifo_full_o;
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, ps_ack_i,
    output wb_ack_o, wb_err_o, ps_req_o, ps_adr_o, ps_dat_o, ps_sel_o,
           fifo_count_o, fifo_empty_o, fifo_full_o
  );
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, ps_ack_i,
    input  wb_ack_o, wb_err_o, ps_req_o, ps_adr_o, ps_dat_o, ps_sel_o,
           fifo_count_o, fifo_empty_o, fifo_full_o
  );
endinterface

// File: rtl/fifo_1rd1wr.sv
// fifo_1rd1wr: simple dual-port RAM, one write port (A) and one registered read port (B)
// clk_a/we_a/addr_a/din_a write; clk_b/en_b/addr_b read, dout_b valid one cycle after en_b.
module fifo_1rd1wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  clk_b,
  input  logic                  en_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dout_b
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  always_ff @(posedge clk_a)
    if (we_a) mem[addr_a] <= din_a;
  always_ff @(posedge clk_b)
    if (en_b) dout_b <= mem[addr_b];
endmodule

// File: rtl/brg_wb2ps_wfifo_ctrl.sv
// brg_wb2ps_wfifo_ctrl: write FIFO between Wishbone classic writes and the PSRAM write-command port
// clk/rst (async, active-high); bus.slave carries Wishbone in, PSRAM req/ack out and FIFO status.
module brg_wb2ps_wfifo_ctrl
  import brg_wb2ps_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WB_AW      = 23
) (
  input logic                   clk,
  input logic                   rst,
  brg_wb2ps_wfifo_ctrl_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  drain_t                state;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_addr;
  logic [ADDR_WIDTH:0]   count, count_n;
  logic                  push, pop, rd_en, count_gt1, rd_cyc;
  entry_t                wr_entry, rd_entry;
  assign push      = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i & ~bus.wb_ack_o & ~bus.fifo_full_o;
  assign rd_cyc    = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_we_i & ~bus.wb_err_o;
  assign pop       = (state == PRESENT) & bus.ps_ack_i;
  assign count_gt1 = |count[ADDR_WIDTH:1];
  // Only entries counted on an earlier edge are fetched, so a same-cycle push is never read back.
  assign rd_en     = ((state == IDLE) & (|count)) | (pop & count_gt1);
  // While presenting, the next read prefetches the slot after the one being acked.
  assign rd_addr   = (state == PRESENT) ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
  assign count_n   = count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
  assign wr_entry  = '{adr: bus.wb_adr_i[WB_AW-1:2], sel: bus.wb_sel_i, dat: bus.wb_dat_i};
  assign bus.ps_adr_o     = rd_entry.adr;
  assign bus.ps_sel_o     = rd_entry.sel;
  assign bus.ps_dat_o     = rd_entry.dat;
  assign bus.fifo_count_o = count;
  fifo_1rd1wr #(
    .DATA_WIDTH(ENTRY_W),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_a (clk),
    .we_a  (push),
    .addr_a(wr_ptr),
    .din_a (wr_entry),
    .clk_b (clk),
    .en_b  (rd_en),
    .addr_b(rd_addr),
    .dout_b(rd_entry)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      bus.fifo_empty_o <= 1'b1;
      bus.fifo_full_o  <= 1'b0;
      bus.wb_ack_o     <= 1'b0;
      bus.wb_err_o     <= 1'b0;
    end else begin
      wr_ptr           <= push ? wr_ptr + ADDR_WIDTH'(1) : wr_ptr;
      rd_ptr           <= pop ? rd_ptr + ADDR_WIDTH'(1) : rd_ptr;
      count            <= count_n;
      bus.fifo_empty_o <= count_n == '0;
      bus.fifo_full_o  <= count_n == FULL_CNT;
      bus.wb_ack_o     <= push;
      bus.wb_err_o     <= rd_cyc;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      bus.ps_req_o <= 1'b0;
    end else begin
      state        <= (state == IDLE)    ? ((|count) ? FETCH : IDLE) :
                      (state == FETCH)   ? PRESENT :
                      ((state == PRESENT) & ~(pop & ~count_gt1)) ? PRESENT : IDLE;
      bus.ps_req_o <= (state == FETCH) | ((state == PRESENT) & ~(pop & ~count_gt1));
    end
endmodule

// File: tb/tb_brg_wb2ps_wfifo_ctrl.sv
// tb_brg_wb2ps_wfifo_ctrl: randomized self-checking bench against a queue-based FIFO model
module tb_brg_wb2ps_wfifo_ctrl;
  localparam int AW = 8, WAW = 23, DEPTH = 256;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  brg_wb2ps_wfifo_ctrl_if #(.ADDR_WIDTH(AW), .WB_AW(WAW)) bus ();
  brg_wb2ps_wfifo_ctrl #(.ADDR_WIDTH(AW), .WB_AW(WAW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int          n_cmp = 0, n_bad = 0, n_pop = 0, wr_left = 0;
  logic [56:0] q[$];
  logic        exp_ack_q = 1'b0, exp_err_q = 1'b0, req_pre = 1'b0;
  logic [31:0] dctr = 32'h0;
  bit          rand_ack = 1'b0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle_bus();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask
  task automatic load_next();
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 23'($urandom);
    bus.wb_dat_i = dctr;
    bus.wb_sel_i = 4'($urandom_range(1, 15));
    dctr++;
  endtask
  task automatic step();
    logic ea, ee, pop;
    logic [56:0] ent;
    if (rand_ack) bus.ps_ack_i = 1'($urandom_range(0, 1));
    ea = bus.wb_cyc_i & bus.wb_stb_i & bus.wb_we_i & ~exp_ack_q & (q.size() < DEPTH);
    ee = bus.wb_cyc_i & bus.wb_stb_i & ~bus.wb_we_i & ~exp_err_q;
    req_pre = bus.ps_req_o;
    pop = bus.ps_req_o & bus.ps_ack_i;
    if (bus.ps_req_o) begin
      chk("req_has_entry", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) chk("ps_entry", {bus.ps_adr_o, bus.ps_sel_o, bus.ps_dat_o}, q[0]);
    end
    ent = {bus.wb_adr_i[22:2], bus.wb_sel_i, bus.wb_dat_i};
    @(posedge clk);
    #1;
    if (pop && q.size() != 0) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (ea) q.push_back(ent);
    exp_ack_q = ea;
    exp_err_q = ee;
    chk("wb_ack", bus.wb_ack_o, ea);
    chk("wb_err", bus.wb_err_o, ee);
    chk("count", bus.fifo_count_o, q.size());
    chk("empty", bus.fifo_empty_o, q.size() == 0);
    chk("full", bus.fifo_full_o, q.size() == DEPTH);
    if (ea) begin
      wr_left--;
      if (wr_left > 0) load_next();
      else idle_bus();
    end
  endtask
  task automatic run_until_drained(input int budget, input string tag);
    int n = 0;
    while ((wr_left > 0 || q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, q.size(), 0);
    chk({tag, "_left"}, wr_left, 0);
  endtask
  initial begin
    int n;
    idle_bus();
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.ps_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", bus.wb_ack_o, 0);
    chk("rst_err", bus.wb_err_o, 0);
    chk("rst_req", bus.ps_req_o, 0);
    chk("rst_count", bus.fifo_count_o, 0);
    chk("rst_empty", bus.fifo_empty_o, 1);
    chk("rst_full", bus.fifo_full_o, 0);
    rst = 1'b0;
    // single write with PSRAM ack tied high
    bus.ps_ack_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 23'h000100;
    bus.wb_dat_i = 32'hDEADBEEF;
    bus.wb_sel_i = 4'hF;
    wr_left = 1;
    n_pop = 0;
    step();
    chk("single_ack", bus.wb_ack_o, 1);
    chk("single_req_c1", bus.ps_req_o, 0);
    step();
    chk("single_req_c2m", bus.ps_req_o, 0);
    step();
    chk("single_req_c2", bus.ps_req_o, 1);
    chk("single_adr", bus.ps_adr_o, 64'h40);
    chk("single_dat", bus.ps_dat_o, 64'hDEADBEEF);
    chk("single_sel", bus.ps_sel_o, 64'hF);
    step();
    chk("single_req_off", bus.ps_req_o, 0);
    chk("single_pops", n_pop, 1);
    // read cycle
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    step();
    chk("read_err", bus.wb_err_o, 1);
    idle_bus();
    step();
    chk("read_err_once", bus.wb_err_o, 0);
    // fill to full with the PSRAM side stalled
    bus.ps_ack_i = 1'b0;
    wr_left = DEPTH + 1;
    load_next();
    n = 0;
    while (q.size() < DEPTH && n < 1000) begin
      step();
      n++;
    end
    chk("fill_full", bus.fifo_full_o, 1);
    chk("fill_count", bus.fifo_count_o, DEPTH);
    repeat (4) step();
    chk("stall_no_ack", bus.wb_ack_o, 0);
    bus.ps_ack_i = 1'b1;
    step();
    bus.ps_ack_i = 1'b0;
    chk("pop_count", bus.fifo_count_o, DEPTH - 1);
    step();
    chk("stall_ack", bus.wb_ack_o, 1);
    bus.ps_ack_i = 1'b1;
    run_until_drained(1000, "fill");
    // ordered drain with wrap under random PSRAM ack
    n_pop = 0;
    rand_ack = 1'b1;
    wr_left = 300;
    load_next();
    run_until_drained(5000, "wrap");
    chk("wrap_pops", n_pop, 300);
    rand_ack = 1'b0;
    // back-to-back drain
    bus.ps_ack_i = 1'b0;
    wr_left = 8;
    load_next();
    n = 0;
    while (wr_left > 0 && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("b2b_queued", bus.fifo_count_o, 8);
    bus.ps_ack_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("b2b_req", req_pre, 1);
    end
    step();
    chk("b2b_done", req_pre, 0);
    // reset mid-drain
    bus.ps_ack_i = 1'b0;
    wr_left = 5;
    load_next();
    n = 0;
    while ((wr_left > 0 || !bus.ps_req_o) && n < 100) begin
      step();
      n++;
    end
    chk("mid_req", bus.ps_req_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", bus.ps_req_o, 0);
    chk("mid_rst_count", bus.fifo_count_o, 0);
    chk("mid_rst_empty", bus.fifo_empty_o, 1);
    q.delete();
    exp_ack_q = 1'b0;
    exp_err_q = 1'b0;
    idle_bus();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_pop = 0;
    bus.ps_ack_i = 1'b1;
    wr_left = 1;
    load_next();
    run_until_drained(50, "post_rst");
    chk("post_rst_pops", n_pop, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
